// File: rtl/quire_readout_ctrl.sv
// Readout sequencer for one quire pass: stall/drain the accumulator, run the
// carry-resolve stage, hand the captured window downstream, optionally clear.
//
// state   | meaning
// IDLE    | accumulator in service, waiting for a host read request
// DRAIN   | accumulator stalled, waiting for DRAIN_CYCLES quiet cycles
// START   | arming the carry-resolve stage (enable strobe goes out next)
// CONVERT | carry walk in progress, bounded by TIMEOUT
// HOLD    | result presented on the valid/ready output
// CLEAR   | quire clear pulse before returning to service
module quire_readout_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 32,
    parameter int FRAC_W       = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              rd_clear,
    output logic              rd_ack,
    input  logic              acc_busy,
    output logic              acc_stall,
    output logic              csa_enable,
    input  logic              csa_finish,
    input  logic [FRAC_W-1:0] csa_frac,
    input  logic [2:0]        csa_blk,
    input  logic              csa_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_frac,
    output logic [2:0]        out_blk,
    output logic              out_sign,
    output logic              quire_clr,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_START,
        S_CONVERT,
        S_HOLD,
        S_CLEAR
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic [7:0] tmo_cnt;
    logic       clr_pend;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            tmo_cnt     <= '0;
            clr_pend    <= 1'b0;
            rd_ack      <= 1'b0;
            acc_stall   <= 1'b0;
            csa_enable  <= 1'b0;
            out_valid   <= 1'b0;
            out_frac    <= '0;
            out_blk     <= '0;
            out_sign    <= 1'b0;
            quire_clr   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_ack     <= 1'b0;
            csa_enable <= 1'b0;
            quire_clr  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        rd_ack      <= 1'b1;
                        clr_pend    <= rd_clear;
                        timeout_err <= 1'b0;
                        drain_cnt   <= '0;
                        acc_stall   <= 1'b1;
                        state       <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // any busy cycle restarts the quiet-cycle count
                    if (acc_busy) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state <= S_START;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                S_START: begin
                    csa_enable <= 1'b1;
                    tmo_cnt    <= '0;
                    state      <= S_CONVERT;
                end
                S_CONVERT: begin
                    // finish takes priority over a coincident timeout
                    if (csa_finish) begin
                        out_frac  <= csa_frac;
                        out_blk   <= csa_blk;
                        out_sign  <= csa_sign;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        acc_stall   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (clr_pend) begin
                            quire_clr <= 1'b1;
                            state     <= S_CLEAR;
                        end else begin
                            acc_stall <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_CLEAR: begin
                    acc_stall <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    acc_stall <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quire_readout_ctrl.sv
// Bench for quire_readout_ctrl: per-pass event times are predicted from the
// request timeline (drain window, finish delay, ready delay) and compared each cycle.
module tb_quire_readout_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int TIMEOUT      = 32;
    localparam int FRAC_W       = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req, rd_clear, rd_ack;
    logic              acc_busy, acc_stall;
    logic              csa_enable, csa_finish;
    logic [FRAC_W-1:0] csa_frac;
    logic [2:0]        csa_blk;
    logic              csa_sign;
    logic              out_valid, out_ready;
    logic [FRAC_W-1:0] out_frac;
    logic [2:0]        out_blk;
    logic              out_sign;
    logic              quire_clr, busy, timeout_err;

    int n_chk = 0;
    int n_err = 0;
    int cur_t = 0;

    quire_readout_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .FRAC_W      (FRAC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_clear   (rd_clear),
        .rd_ack     (rd_ack),
        .acc_busy   (acc_busy),
        .acc_stall  (acc_stall),
        .csa_enable (csa_enable),
        .csa_finish (csa_finish),
        .csa_frac   (csa_frac),
        .csa_blk    (csa_blk),
        .csa_sign   (csa_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frac   (out_frac),
        .out_blk    (out_blk),
        .out_sign   (out_sign),
        .quire_clr  (quire_clr),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog t=%0d got no finish exp finish", cur_t);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got %0h exp %0h", tag, cur_t, got, exp);
        end
    endtask

    task automatic noise_inputs();
        csa_frac = {$urandom, $urandom, $urandom, $urandom};
        csa_blk  = 3'($urandom_range(0, 7));
        csa_sign = 1'($urandom_range(0, 1));
    endtask

    // quiet IDLE cycles with junk on every input except rd_req
    task automatic idle_cycles(input int n, input bit exp_tmo);
        for (int i = 0; i < n; i++) begin
            cur_t      = -100 - i;
            rd_req     = 1'b0;
            rd_clear   = 1'($urandom_range(0, 1));
            acc_busy   = 1'($urandom_range(0, 1));
            csa_finish = ($urandom_range(0, 2) == 0);
            out_ready  = 1'($urandom_range(0, 1));
            noise_inputs();
            @(negedge clk);
            chk("idle_ack", rd_ack, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_stall", acc_stall, 1'b0);
            chk("idle_valid", out_valid, 1'b0);
            chk("idle_clr", quire_clr, 1'b0);
            chk("idle_en", csa_enable, 1'b0);
            chk("idle_tmo", timeout_err, exp_tmo);
            @(posedge clk); #1;
        end
    endtask

    task automatic start_req(input bit clr, input bit exp_tmo);
        cur_t      = -1;
        rd_req     = 1'b1;
        rd_clear   = clr;
        acc_busy   = 1'($urandom_range(0, 1));
        csa_finish = 1'($urandom_range(0, 1));
        out_ready  = 1'($urandom_range(0, 1));
        noise_inputs();
        @(negedge clk);
        chk("req_ack", rd_ack, 1'b0);
        chk("req_busy", busy, 1'b0);
        chk("req_tmo", timeout_err, exp_tmo);
        @(posedge clk); #1;
    endtask

    // One pass; t=0 is the cycle rd_ack should be high. fin_k<0 means no finish;
    // rdy_r<0 means out_ready already high before out_valid.
    task automatic run_pass(input bit clr, input logic [15:0] bpat, input int fin_k,
                            input int rdy_r, input bit chain, input bit next_clr,
                            output bit tmo);
        int run, e, v, h, last_busy;
        bit in_conv, want_valid;
        logic [FRAC_W-1:0] cap_frac;
        logic [2:0] cap_blk;
        logic cap_sign;
        tmo = (fin_k < 0);
        cap_frac = '0; cap_blk = '0; cap_sign = 1'b0;
        // enable lands two cycles after the cycle closing DRAIN_CYCLES quiet cycles
        run = 0; e = -1;
        for (int t = 0; t < 40 && e < 0; t++) begin
            run = (t < 16 && bpat[t]) ? 0 : run + 1;
            if (run == DRAIN_CYCLES) e = t + 2;
        end
        v = e + fin_k + 1;
        h = v + ((rdy_r > 0) ? rdy_r : 0);
        last_busy = tmo ? e + TIMEOUT - 1 : h + int'(clr);
        for (int t = 0; t <= last_busy + 1; t++) begin
            cur_t    = t;
            rd_req   = chain;
            rd_clear = (chain && t == last_busy + 1) ? next_clr : 1'($urandom_range(0, 1));
            acc_busy = (t < e - 1) ? (t < 16 && bpat[t]) : 1'($urandom_range(0, 1));
            in_conv  = (t >= e) && (tmo ? (t < e + TIMEOUT) : (t <= e + fin_k));
            csa_finish = in_conv ? (!tmo && t == e + fin_k) : ($urandom_range(0, 3) == 0);
            noise_inputs();
            if (!tmo && t == e + fin_k) begin
                cap_frac = csa_frac;
                cap_blk  = csa_blk;
                cap_sign = csa_sign;
            end
            if (rdy_r < 0)
                out_ready = (t >= v - 3) ? 1'b1 : 1'($urandom_range(0, 1));
            else if (t < v)
                out_ready = 1'($urandom_range(0, 1));
            else
                out_ready = (t >= v + rdy_r);
            @(negedge clk);
            want_valid = !tmo && t >= v && t <= h;
            chk("rd_ack", rd_ack, t == 0);
            chk("csa_enable", csa_enable, t == e);
            chk("out_valid", out_valid, want_valid);
            if (want_valid) begin
                chk("out_frac", out_frac, cap_frac);
                chk("out_blk", out_blk, cap_blk);
                chk("out_sign", out_sign, cap_sign);
            end
            chk("quire_clr", quire_clr, !tmo && clr && t == h + 1);
            chk("acc_stall", acc_stall, t <= last_busy);
            chk("busy", busy, t <= last_busy);
            chk("timeout_err", timeout_err, tmo && t >= e + TIMEOUT);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit tmo, found, clr, clr_n, chain;
        logic [15:0] bpat;
        int fin_k, rdy_r;
        rst = 1'b1;
        rd_req = 1'b0; rd_clear = 1'b0; acc_busy = 1'b0; csa_finish = 1'b0;
        out_ready = 1'b0; csa_frac = '0; csa_blk = '0; csa_sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", rd_ack, 1'b0);
        chk("rst_stall", acc_stall, 1'b0);
        chk("rst_en", csa_enable, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_clr", quire_clr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);
        chk("rst_frac", out_frac, '0);
        rst = 1'b0;
        idle_cycles(2, 1'b0);

        // basic pass, drain restart, backpressure with clear
        start_req(1'b0, 1'b0);
        run_pass(1'b0, 16'h0000, 9, -1, 1'b0, 1'b0, tmo);
        idle_cycles(2, tmo);
        start_req(1'b0, tmo);
        run_pass(1'b0, 16'h0004, 9, 0, 1'b0, 1'b0, tmo);
        idle_cycles(2, tmo);
        start_req(1'b1, tmo);
        run_pass(1'b1, 16'h0000, 5, 6, 1'b0, 1'b0, tmo);
        idle_cycles(2, tmo);

        // timeout, then the flag is cleared by the next accepted request
        start_req(1'b1, tmo);
        run_pass(1'b1, 16'h0000, -1, 0, 1'b0, 1'b0, tmo);
        idle_cycles(3, tmo);
        start_req(1'b0, tmo);
        // finish on the last CONVERT cycle beats the timeout; held request chains
        run_pass(1'b0, 16'h0000, TIMEOUT - 1, 2, 1'b1, 1'b1, tmo);
        run_pass(1'b1, 16'h0000, 3, 1, 1'b0, 1'b0, tmo);
        idle_cycles(2, tmo);

        // async reset while the result is held
        start_req(1'b1, tmo);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            cur_t = t;
            rd_req = 1'b0; acc_busy = 1'b0; out_ready = 1'b0;
            csa_finish = (t == 8);
            noise_inputs();
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_reach_hold", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_stall", acc_stall, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(5, 1'b0);

        // randomized passes
        tmo = 1'b0;
        clr_n = 1'($urandom_range(0, 1));
        start_req(clr_n, tmo);
        for (int p = 0; p < 30; p++) begin
            clr   = clr_n;
            clr_n = 1'($urandom_range(0, 1));
            chain = (p < 29) && ($urandom_range(0, 2) == 0);
            bpat  = 16'($urandom & $urandom & 32'h0000_0FFF);
            fin_k = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            rdy_r = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 6));
            run_pass(clr, bpat, fin_k, rdy_r, chain, clr_n, tmo);
            if (!chain && p < 29) begin
                idle_cycles(int'($urandom_range(1, 4)), tmo);
                start_req(clr_n, tmo);
            end
        end
        idle_cycles(2, tmo);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
